// File: rtl/microcode_sequencer_if.sv
// Fetch-unit and microcode-ROM handshake bundle for microcode_sequencer.
// master = sequencer side, slave = fetch unit / ROM side.
interface microcode_sequencer_if;
  logic       fetch_valid;
  logic [7:0] fetch_byte;
  logic       fetch_ack;
  logic [8:0] uop_addr;
  logic       uop_commit;
  logic       ctrl_last;
  logic [8:0] ctrl_next;
  logic       ctrl_mem_req;
  logic       ctrl_halt;
  logic       mem_ready;

  modport master (
    input  fetch_valid, fetch_byte, ctrl_last, ctrl_next, ctrl_mem_req, ctrl_halt, mem_ready,
    output fetch_ack, uop_addr, uop_commit
  );

  modport slave (
    output fetch_valid, fetch_byte, ctrl_last, ctrl_next, ctrl_mem_req, ctrl_halt, mem_ready,
    input  fetch_ack, uop_addr, uop_commit
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Game Boy microcode sequencer: opcode fetch, CB prefix folding, micro-step walk, HALT.
// Define INT_DISPATCH_EN to enable interrupt entry from FETCH and HALT.
//
// state  | meaning
// FETCH  | waiting for an opcode byte (or interrupt entry)
// PREFIX | CB seen, waiting for the second opcode byte
// EXEC   | stepping through micro-words; stalls on memory wait
// HALT   | sleeping until an interrupt is pending
module microcode_sequencer #(
  parameter logic [8:0] INT_UADDR = 9'h0D3,
  parameter int         MAX_STEPS = 8,
  parameter int         STEP_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  microcode_sequencer_if.master bus,
  input  logic                  int_pending,
  input  logic                  ime,
  output logic                  int_ack,
  output logic                  halted,
  output logic                  cb_active,
  output logic [STEP_W-1:0]     step,
  output logic                  ucode_error
);

  typedef enum logic [1:0] {S_FETCH, S_PREFIX, S_EXEC, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [8:0]          uop_addr_q, uop_addr_d;
  logic [STEP_W-1:0]   step_q, step_d, step_inc;
  logic                cb_q, cb_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic                int_take;
  logic                fetch_ack_c, commit_c, int_ack_c;

`ifdef INT_DISPATCH_EN
  assign int_take = int_pending & ime;
`else
  logic unused_ime;
  assign unused_ime = ime;
  assign int_take   = 1'b0;
`endif

  assign step_inc = step_q + STEP_W'(1);

  always_comb begin
    state_d     = state_q;
    uop_addr_d  = uop_addr_q;
    step_d      = step_q;
    cb_d        = cb_q;
    halted_d    = halted_q;
    err_d       = err_q;
    fetch_ack_c = 1'b0;
    commit_c    = 1'b0;
    int_ack_c   = 1'b0;
    // Reset abandons the current cycle: no handshake or commit may escape.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (int_take) begin
            int_ack_c  = 1'b1;
            uop_addr_d = INT_UADDR;
            cb_d       = 1'b0;
            step_d     = '0;
            state_d    = S_EXEC;
          end else if (bus.fetch_valid) begin
            fetch_ack_c = 1'b1;
            if (bus.fetch_byte == 8'hCB) begin
              cb_d    = 1'b1;
              state_d = S_PREFIX;
            end else begin
              uop_addr_d = {1'b0, bus.fetch_byte};
              cb_d       = 1'b0;
              step_d     = '0;
              state_d    = S_EXEC;
            end
          end
        end
        S_PREFIX: begin
          if (bus.fetch_valid) begin
            fetch_ack_c = 1'b1;
            uop_addr_d  = {1'b1, bus.fetch_byte};
            step_d      = '0;
            state_d     = S_EXEC;
          end
        end
        S_EXEC: begin
          commit_c = !bus.ctrl_mem_req || bus.mem_ready;
          if (commit_c) begin
            if (bus.ctrl_halt) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else if (bus.ctrl_last) begin
              state_d = S_FETCH;
            end else if (step_inc == STEP_W'(MAX_STEPS)) begin
              err_d   = 1'b1;
              state_d = S_FETCH;
            end else begin
              uop_addr_d = bus.ctrl_next;
              step_d     = step_inc;
            end
          end
        end
        S_HALT: begin
          if (int_pending) begin
            halted_d = 1'b0;
            if (int_take) begin
              int_ack_c  = 1'b1;
              uop_addr_d = INT_UADDR;
              cb_d       = 1'b0;
              step_d     = '0;
              state_d    = S_EXEC;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      uop_addr_q <= '0;
      step_q     <= '0;
      cb_q       <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      uop_addr_q <= uop_addr_d;
      step_q     <= step_d;
      cb_q       <= cb_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign bus.fetch_ack  = fetch_ack_c;
  assign bus.uop_addr   = uop_addr_q;
  assign bus.uop_commit = commit_c;
  assign int_ack        = int_ack_c;
  assign halted         = halted_q;
  assign cb_active      = cb_q;
  assign step           = step_q;
  assign ucode_error    = err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer; expectations follow INT_DISPATCH_EN when defined.
module tb_microcode_sequencer;
  logic       clock = 1'b0;
  logic       reset;
  logic       int_pending, ime;
  logic       int_ack, halted, cb_active, ucode_error;
  logic [3:0] step;
  int         vec_cnt = 0;
  int         err_cnt = 0;

`ifdef INT_DISPATCH_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  microcode_sequencer_if bus_if ();

  microcode_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if.master),
    .int_pending (int_pending),
    .ime         (ime),
    .int_ack     (int_ack),
    .halted      (halted),
    .cb_active   (cb_active),
    .step        (step),
    .ucode_error (ucode_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a byte, check it is acked, consume it on the next edge.
  task automatic fetch(input string tag, input logic [7:0] b);
    bus_if.fetch_valid = 1'b1;
    bus_if.fetch_byte  = b;
    #1 chk(tag, bus_if.fetch_ack, 1);
    tick();
    bus_if.fetch_valid = 1'b0;
    #1;
  endtask

  // Probe for FETCH without consuming: ack appears only in FETCH/PREFIX.
  task automatic probe_ack(input string tag, input logic exp);
    bus_if.fetch_valid = 1'b1;
    bus_if.fetch_byte  = 8'h00;
    #1 chk(tag, bus_if.fetch_ack, exp);
    bus_if.fetch_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; int_pending = 1'b0; ime = 1'b0;
    bus_if.fetch_valid = 1'b1; bus_if.fetch_byte = 8'h00;
    bus_if.ctrl_last = 1'b1; bus_if.ctrl_next = 9'h000;
    bus_if.ctrl_mem_req = 1'b0; bus_if.ctrl_halt = 1'b0; bus_if.mem_ready = 1'b0;
    tick(); tick();
    chk("rst_ack", bus_if.fetch_ack, 0);
    chk("rst_addr", bus_if.uop_addr, 9'h000);
    chk("rst_step", step, 0);
    chk("rst_cb", cb_active, 0);
    chk("rst_halt", halted, 0);
    chk("rst_err", ucode_error, 0);
    chk("rst_commit", bus_if.uop_commit, 0);
    chk("rst_intack", int_ack, 0);
    bus_if.fetch_valid = 1'b0;
    reset = 1'b0;
    #1;

    // single-step opcode 00
    fetch("nop_ack", 8'h00);
    chk("nop_addr", bus_if.uop_addr, 9'h000);
    chk("nop_commit", bus_if.uop_commit, 1);
    probe_ack("nop_exec_noack", 0);
    tick();
    chk("nop_fetch_commit", bus_if.uop_commit, 0);
    probe_ack("nop_back_fetch", 1);

    // CB 37
    fetch("cb_ack1", 8'hCB);
    chk("cb_prefix_cb", cb_active, 1);
    chk("cb_prefix_commit", bus_if.uop_commit, 0);
    fetch("cb_ack2", 8'h37);
    chk("cb_addr", bus_if.uop_addr, 9'h137);
    chk("cb_active", cb_active, 1);
    chk("cb_commit", bus_if.uop_commit, 1);
    tick();
    chk("cb_done_commit", bus_if.uop_commit, 0);

    // CB CB folds to 1CB
    fetch("cbcb_ack1", 8'hCB);
    fetch("cbcb_ack2", 8'hCB);
    chk("cbcb_addr", bus_if.uop_addr, 9'h1CB);
    tick();

    // 3-step with memory stall on step 1
    bus_if.ctrl_last = 1'b0; bus_if.ctrl_next = 9'h0D3;
    fetch("ms_ack", 8'h10);
    chk("ms_s0_commit", bus_if.uop_commit, 1);
    chk("ms_s0_cb", cb_active, 0);
    tick();
    bus_if.ctrl_next = 9'h0DB; bus_if.ctrl_mem_req = 1'b1; bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ms_stall_commit", bus_if.uop_commit, 0);
      chk("ms_stall_addr", bus_if.uop_addr, 9'h0D3);
      chk("ms_stall_step", step, 1);
      tick();
    end
    bus_if.mem_ready = 1'b1;
    #1 chk("ms_s1_commit", bus_if.uop_commit, 1);
    tick();
    bus_if.ctrl_mem_req = 1'b0; bus_if.mem_ready = 1'b0; bus_if.ctrl_last = 1'b1;
    #1;
    chk("ms_s2_addr", bus_if.uop_addr, 9'h0DB);
    chk("ms_s2_step", step, 2);
    chk("ms_s2_commit", bus_if.uop_commit, 1);
    tick();
    chk("ms_end_step", step, 2);
    probe_ack("ms_back_fetch", 1);

    // runaway instruction: ctrl_last never set
    bus_if.ctrl_last = 1'b0; bus_if.ctrl_next = 9'h050;
    fetch("run_ack", 8'h20);
    for (int i = 0; i < 8; i++) begin
      chk("run_step", step, i);
      chk("run_err_pre", ucode_error, 0);
      chk("run_commit", bus_if.uop_commit, 1);
      tick();
    end
    chk("run_err", ucode_error, 1);
    chk("run_commit_after", bus_if.uop_commit, 0);
    probe_ack("run_back_fetch", 1);
    bus_if.ctrl_last = 1'b1;

    // HALT woken with ime=1
    fetch("h1_ack", 8'h76);
    bus_if.ctrl_halt = 1'b1;
    #1 chk("h1_commit", bus_if.uop_commit, 1);
    tick();
    bus_if.ctrl_halt = 1'b0;
    chk("h1_halted", halted, 1);
    chk("h1_commit_halt", bus_if.uop_commit, 0);
    probe_ack("h1_noack", 0);
    tick();
    chk("h1_still", halted, 1);
    int_pending = 1'b1; ime = 1'b1;
    #1 chk("h1_intack", int_ack, INT_ON);
    tick();
    int_pending = 1'b0;
    #1;
    chk("h1_wake", halted, 0);
    chk("h1_intack_once", int_ack, 0);
    if (INT_ON) begin
      chk("h1_int_addr", bus_if.uop_addr, 9'h0D3);
      chk("h1_int_step", step, 0);
      chk("h1_int_commit", bus_if.uop_commit, 1);
      tick();
    end else begin
      chk("h1_keep_addr", bus_if.uop_addr, 9'h076);
      chk("h1_fetch_commit", bus_if.uop_commit, 0);
    end
    probe_ack("h1_back_fetch", 1);

    // HALT woken with ime=0
    ime = 1'b0;
    fetch("h0_ack", 8'h76);
    bus_if.ctrl_halt = 1'b1;
    tick();
    bus_if.ctrl_halt = 1'b0;
    chk("h0_halted", halted, 1);
    int_pending = 1'b1;
    #1 chk("h0_intack", int_ack, 0);
    tick();
    int_pending = 1'b0;
    chk("h0_wake", halted, 0);
    chk("h0_commit", bus_if.uop_commit, 0);
    probe_ack("h0_back_fetch", 1);
    chk("err_sticky", ucode_error, 1);

    // interrupt vs fetch in the same cycle, then reset mid-EXEC
    int_pending = 1'b1; ime = 1'b1;
    bus_if.fetch_valid = 1'b1; bus_if.fetch_byte = 8'h3C;
    #1;
    chk("race_ack", bus_if.fetch_ack, !INT_ON);
    chk("race_intack", int_ack, INT_ON);
    tick();
    bus_if.fetch_valid = 1'b0;
    #1 chk("race_addr", bus_if.uop_addr, INT_ON ? 9'h0D3 : 9'h03C);
    reset = 1'b1;
    bus_if.fetch_valid = 1'b1;
    #1 chk("mid_rst_commit", bus_if.uop_commit, 0);
    tick();
    chk("post_rst_addr", bus_if.uop_addr, 9'h000);
    chk("post_rst_step", step, 0);
    chk("post_rst_cb", cb_active, 0);
    chk("post_rst_halt", halted, 0);
    chk("post_rst_err", ucode_error, 0);
    chk("post_rst_commit", bus_if.uop_commit, 0);
    chk("post_rst_ack", bus_if.fetch_ack, 0);
    chk("post_rst_intack", int_ack, 0);
    reset = 1'b0; int_pending = 1'b0; ime = 1'b0; bus_if.fetch_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Drives the 9-bit opcode/micro-address input of the microcode ROM.
- Walks each Game Boy instruction through its micro-steps.
- Folds the CB prefix into address bit 8.
- Stalls on memory wait, handles HALT and interrupt entry.
- Sits between the fetch unit and the microcode ROM and gates when the ROM's 70-bit control word may commit.

Parameters:
- INT_UADDR, 9'h0D3: micro-address of the interrupt-entry sequence (unused opcode slot D3).
- MAX_STEPS, 8: maximum micro-steps per instruction before an error abort.
- STEP_W, 4: width of the step counter; must satisfy 2^STEP_W > MAX_STEPS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch unit presents an opcode byte.
- fetch_byte  in  8  opcode byte.
- fetch_ack  out  1  byte consumed this cycle (combinational).
- uop_addr  out  9  registered address to the microcode ROM.
- uop_commit  out  1  the current control word takes effect this cycle (combinational).
- ctrl_last  in  1  control-word field: final step of the instruction.
- ctrl_next  in  9  control-word field: next micro-address when not last.
- ctrl_mem_req  in  1  control-word field: step performs a bus access.
- ctrl_halt  in  1  control-word field: enter HALT after this step.
- mem_ready  in  1  bus access completes this cycle.
- int_pending  in  1  (IE & IF) is non-zero.
- ime  in  1  interrupt master enable.
- int_ack  out  1  one-cycle pulse when interrupt entry begins.
- halted  out  1  sequencer is in HALT.
- cb_active  out  1  current instruction is CB-prefixed.
- step  out  STEP_W  micro-step index within the current instruction.
- ucode_error  out  1  sticky flag: MAX_STEPS exceeded; cleared only by reset.

Behaviour:
- States: FETCH, PREFIX, EXEC, HALT. Reset sets:
  - state to FETCH
  - uop_addr to 0, step to 0
  - cb_active, halted, ucode_error to 0
  - combinational outputs fetch_ack, uop_commit, int_ack to 0.
  Reset takes priority mid-instruction; any in-progress step is abandoned with no commit.
- FETCH:
  - Interrupt has priority. If int_pending && ime, and the optional interrupt feature is compiled in:
    - int_ack=1, fetch_ack=0
    - uop_addr<=INT_UADDR, cb_active<=0, step<=0
    - next state EXEC.
  - Otherwise, if fetch_valid: fetch_ack=1.
    - If fetch_byte==8'hCB: next state PREFIX, cb_active<=1.
    - Otherwise: uop_addr<={1'b0,fetch_byte}, cb_active<=0, step<=0, next state EXEC.
  - Otherwise stay in FETCH.
- PREFIX:
  - Interrupts are not taken.
  - On fetch_valid: fetch_ack=1, uop_addr<={1'b1,fetch_byte}, step<=0, next state EXEC.
  - A second CB byte is treated as a normal CB opcode, address 9'h1CB.
- EXEC:
  - uop_commit = !ctrl_mem_req || mem_ready.
  - If not committing, hold uop_addr and step (memory stall, any length).
  - On commit, in priority order:
    1. ctrl_halt: next state HALT, halted<=1.
    2. ctrl_last: next state FETCH.
    3. Otherwise: uop_addr<=ctrl_next, step<=step+1.
  - If the step about to advance would reach MAX_STEPS: set ucode_error, next state FETCH.
- Latency: the byte is acked in cycle N; the first commit is at earliest cycle N+1. A non-prefixed single-step instruction with no memory stall needs 2 cycles (FETCH, EXEC). CB-prefixed instructions add 1 cycle.
- HALT:
  - uop_commit=0, fetch_ack=0.
  - On int_pending: halted<=0. Then if ime and the feature is compiled in, go to interrupt entry exactly as in FETCH, in the same cycle. Otherwise go to FETCH.
- uop_commit is never asserted outside EXEC. fetch_ack is never asserted in EXEC or HALT.

Optional Feature:
- Macro INT_DISPATCH_EN.
- Defined: interrupt entry in FETCH and HALT as described above.
- Undefined: int_ack is tied 0 and ime is ignored. int_pending only wakes HALT, which returns to FETCH.

Test Plan:
- Reset, then fetch_byte=8'h00 with fetch_valid, ctrl_last=1, ctrl_mem_req=0:
  - fetch_ack in cycle 1.
  - uop_addr=9'h000 and uop_commit=1 in cycle 2.
  - State back to FETCH in cycle 3.
- Bytes 8'hCB then 8'h37, ctrl_last=1:
  - Two fetch_acks.
  - uop_addr=9'h137, cb_active=1, one commit.
- 3-step instruction, ctrl_next chain 9'h0D3→9'h0DB, step-1 ctrl_mem_req=1 with mem_ready low for 4 cycles:
  - uop_addr and step held for 4 cycles with uop_commit=0.
  - Commits at steps 0,1,2; step ends at 2.
- ctrl_last never set:
  - ucode_error=1 after the 8th step's commit.
  - Returns to FETCH; flag stays set until reset.
- ctrl_halt on commit:
  - halted=1.
  - int_pending=1, ime=1 (INT_DISPATCH_EN defined): int_ack pulses once and uop_addr=9'h0D3.
  - With ime=0: returns to FETCH, int_ack stays 0.
- int_pending=1, ime=1 and fetch_valid=1 in the same FETCH cycle:
  - Interrupt wins: fetch_ack=0, int_ack=1.
  - Assert reset during the subsequent EXEC: all outputs at reset values on the next cycle.
